// File: rtl/cond_logic.sv
// Conditional-execution stage: holds the NZCV flags, evaluates the condition field
// against them, and gates the decoder write intents into the final strobes.
module cond_logic #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       En,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [1:0] nz;
  logic [1:0] cv;
  logic       cond_pass;
  logic       cond_ok;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic r;
    {n, z, c, v} = f;
    case (cond)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign Flags = {nz, cv};

  // Condition is judged on the stored flags, so an instruction never sees its own result.
  always_comb begin
    cond_pass = cond_eval(Cond, Flags);
  end

  assign CondEx   = cond_pass & ~reset;
  assign cond_ok  = En & CondEx;
  assign PCSrc    = cond_ok & PCS;
  assign RegWrite = cond_ok & RegW & ~NoWrite;
  assign MemWrite = cond_ok & MemW;

  // Flag register stage: NZ and CV halves update independently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nz <= FLAG_RESET[3:2];
      cv <= FLAG_RESET[1:0];
    end else begin
      if (En & cond_pass & FlagW[1]) nz <= ALUFlags[3:2];
      if (En & cond_pass & FlagW[0]) cv <= ALUFlags[1:0];
    end
  end

endmodule
